deserializer: RTL and testbench
===============================

# deserializer

Receive-side counterpart to the padded-frame serializer. It samples the serial bit stream and its per-frame trigger and strips the leading and trailing zero padding. It checks framing, then presents the recovered data word in parallel with a one-cycle valid strobe. It sits directly downstream of the serializer (loopback and link test path) and feeds the parallel-word consumer.

## Interface
- `NumbDataBits`, 8: data bits per frame; legal range 1..56.
- `NumbLeadingZeros`, 4: padding zeros before data. Bit 0 of the padding coincides with `Trigger`. Minimum 1.
- `NumbTrailingZeros`, 4: padding zeros after data; minimum 1.
- `Clk`  input  1  single clock; all logic on rising edge.
- `Clr`  input  1  reset; asynchronous, active-low (0 = reset asserted).
- `Trigger`  input  1  high for one cycle on the first leading-padding bit of a frame.
- `InputBit`  input  1  serial data, MSB of data first, one bit per `Clk`.
- `DataOut`  output  `NumbDataBits`  last good word; holds between frames.
- `DataValid`  output  1  one-cycle pulse when `DataOut` is updated.
- `FrameError`  output  1  one-cycle pulse on a rejected frame.
- `Busy`  output  1  high while a frame is being received.
- `ErrorCount`  output  8  rejected frames since reset; saturates at 255.

## Operation
- Frame length: `ContentSize` = `NumbLeadingZeros` + `NumbDataBits` + `NumbTrailingZeros`.
- Position counter `Pos`: width clog2(`ContentSize`). Set to 0 in the cycle `Trigger` is sampled high.
- States:
  - IDLE: waiting for `Trigger`.
  - LEAD: `Pos` < `NumbLeadingZeros`.
  - DATA: `Pos` in `NumbLeadingZeros` .. `NumbLeadingZeros`+`NumbDataBits`-1.
  - TRAIL: remaining positions.
- Transitions:
  - IDLE → LEAD on `Trigger`.
  - LEAD → DATA, then DATA → TRAIL, by `Pos` boundary.
  - TRAIL → IDLE after the bit at `Pos` = `ContentSize`-1 is sampled.
- LEAD and TRAIL bits must be 0. Any 1 sets an internal error flag for the current frame.
- DATA bits shift into an internal register, MSB first: `shift <= {shift[N-2:0], InputBit}`.
- Frame completion, after the last TRAIL bit:
  - Error flag clear: load `DataOut` from the shift register and pulse `DataValid`.
  - Error flag set: pulse `FrameError`, increment `ErrorCount`, leave `DataOut` unchanged.
- Early trigger: `Trigger` high in LEAD, DATA or TRAIL before the last TRAIL bit means the current frame is aborted.
  - `FrameError` pulses and `ErrorCount` increments.
  - A new frame starts at `Pos` = 0 with the error flag cleared.
- A `Trigger` high at `Pos` = `ContentSize`-1 also counts as early: abort and restart.
- `InputBit` is ignored in IDLE.
- `Busy` = 1 in LEAD, DATA and TRAIL; 0 in IDLE.
- `ErrorCount` does not wrap: 255 + 1 = 255.

## Timing
- All outputs are registered.
- Reset values (while `Clr` = 0):
  - `DataOut` = 0, `DataValid` = 0, `FrameError` = 0, `Busy` = 0, `ErrorCount` = 0.
  - State IDLE, `Pos` = 0, shift register 0, error flag 0.
- Reset asserted mid-frame discards the frame immediately, with no `FrameError` pulse. The first `Trigger` after `Clr` returns high starts a fresh frame.
- `Trigger` sampled at cycle t:
  - Data MSB sampled at t+`NumbLeadingZeros`.
  - Last TRAIL bit sampled at t+`ContentSize`-1.
  - `DataValid`/`FrameError` high and `DataOut` updated at t+`ContentSize`.
  - Latency is `ContentSize` cycles from trigger to strobe.
- `Busy` rises at t+1 and falls at t+`ContentSize`.
- Back-to-back frames: the next `Trigger` at t+`ContentSize` is accepted in the same cycle the strobe is high. Continuous serializer output produces one strobe every `ContentSize` cycles with no lost frames.
- Early-trigger abort: the `FrameError` pulse appears the cycle after the offending `Trigger`. That cycle also counts as `Pos` = 1 of the new frame.
- `DataValid` and `FrameError` are never high in the same cycle.

## Test plan
1. Single good frame. N=8, 4/4 padding, data 0xA5, `Trigger` at cycle 10 → `DataValid` high only at cycle 26, `DataOut` = 0xA5, `FrameError` 0, `Busy` high cycles 11..25.
2. Back-to-back frames. 0x3C, 0xFF, 0x01 with triggers 16 cycles apart → three `DataValid` pulses 16 cycles apart, `DataOut` 0x3C, 0xFF, 0x01, `ErrorCount` 0.
3. Padding violation. 0x5A with a 1 in trailing bit 2 → no `DataValid`, `FrameError` pulse at t+16, `DataOut` keeps the previous word, `ErrorCount` = 1.
4. Early trigger. Second `Trigger` 7 cycles after the first, then a clean 0x81 frame → `FrameError` at first t+8, `DataValid` with 0x81 at second t+16, `ErrorCount` = 1.
5. Reset mid-frame. `Clr` low during DATA, then a clean 0xC3 frame → all outputs 0 immediately, no `FrameError`, next frame gives `DataOut` = 0xC3.
6. Saturation and edges. 260 frames with padding errors → `ErrorCount` stops at 255. With N=1, frames of bit 1 then 0 → `DataOut` 1 then 0, frame period 9 cycles.

Source files
------------

// File: rtl/deserializer.sv
// deserializer
// Receive side of the padded-frame serial link. A frame is NumbLeadingZeros
// zeros, NumbDataBits data bits (MSB first) and NumbTrailingZeros zeros.
// The first leading zero coincides with Trigger. Padding is checked, and
// good frames are presented in parallel with a one-cycle strobe.
//
// Ports:
//   Clk        in   clock, rising edge
//   Clr        in   asynchronous reset, active low
//   Trigger    in   one-cycle marker on the first padding bit of a frame
//   InputBit   in   serial data, one bit per clock
//   DataOut    out  last good data word, held between frames
//   DataValid  out  one-cycle pulse when DataOut is updated
//   FrameError out  one-cycle pulse on a rejected or aborted frame
//   Busy       out  high while a frame is being received
//   ErrorCount out  saturating count of rejected frames
module deserializer #(
  parameter int NumbDataBits      = 8,
  parameter int NumbLeadingZeros  = 4,
  parameter int NumbTrailingZeros = 4
) (
  input  logic                    Clk,
  input  logic                    Clr,
  input  logic                    Trigger,
  input  logic                    InputBit,
  output logic [NumbDataBits-1:0] DataOut,
  output logic                    DataValid,
  output logic                    FrameError,
  output logic                    Busy,
  output logic [7:0]              ErrorCount
);

  localparam int ContentSize = NumbLeadingZeros + NumbDataBits + NumbTrailingZeros;
  localparam int PosW        = $clog2(ContentSize);

  localparam logic [PosW-1:0] PosZero       = PosW'(0);
  localparam logic [PosW-1:0] PosOne        = PosW'(1);
  localparam logic [PosW-1:0] PosLast       = PosW'(ContentSize - 1);
  localparam logic [PosW-1:0] PosDataFirst  = PosW'(NumbLeadingZeros);
  localparam logic [PosW-1:0] PosTrailFirst = PosW'(NumbLeadingZeros + NumbDataBits);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LEAD  = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] TRAIL = 2'd3;

  // pos_q is the frame position of the bit sampled at the next edge, and
  // state_q is the region that position falls in.
  logic [1:0]              state_q, state_d;
  logic [PosW-1:0]         pos_q, pos_d;
  logic [NumbDataBits-1:0] shift_q, shift_d;
  logic                    err_q, err_d;
  logic                    err_s;
  logic [NumbDataBits-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    ferr_q, ferr_d;
  logic                    busy_q, busy_d;
  logic [7:0]              cnt_q, cnt_d;

  function automatic logic [1:0] region_of(input logic [PosW-1:0] p);
    if (p < PosDataFirst) begin
      return LEAD;
    end else if (p < PosTrailFirst) begin
      return DATA;
    end else begin
      return TRAIL;
    end
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    if (c == 8'hFF) begin
      return c;
    end else begin
      return c + 8'd1;
    end
  endfunction

  // Next-state logic: frame start/abort, bit classification, completion.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    shift_d = shift_q;
    err_d   = err_q;
    err_s   = err_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    if (Trigger) begin
      // A trigger while a frame is open (including its last bit) aborts it.
      if (state_q != IDLE) begin
        ferr_d = 1'b1;
        cnt_d  = sat_inc(cnt_q);
      end else begin
        ferr_d = 1'b0;
        cnt_d  = cnt_q;
      end
      // The trigger cycle carries padding bit 0, so it is checked here.
      state_d = region_of(PosOne);
      pos_d   = PosOne;
      shift_d = {NumbDataBits{1'b0}};
      err_d   = InputBit;
      busy_d  = 1'b1;
    end else if (state_q == IDLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        DATA:        shift_d = (shift_q << 1'b1) | NumbDataBits'(InputBit);
        LEAD, TRAIL: err_s   = err_q | InputBit;
        default:     err_s   = err_q;
      endcase
      if (pos_q == PosLast) begin
        state_d = IDLE;
        pos_d   = PosZero;
        busy_d  = 1'b0;
        err_d   = 1'b0;
        if (err_s) begin
          ferr_d = 1'b1;
          cnt_d  = sat_inc(cnt_q);
        end else begin
          valid_d = 1'b1;
          data_d  = shift_d;
        end
      end else begin
        pos_d   = pos_q + PosOne;
        state_d = region_of(pos_q + PosOne);
        err_d   = err_s;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q <= IDLE;
      pos_q   <= PosZero;
      shift_q <= {NumbDataBits{1'b0}};
      err_q   <= 1'b0;
      data_q  <= {NumbDataBits{1'b0}};
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      shift_q <= shift_d;
      err_q   <= err_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign DataOut    = data_q;
  assign DataValid  = valid_q;
  assign FrameError = ferr_q;
  assign Busy       = busy_q;
  assign ErrorCount = cnt_q;

endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer
// Self-checking bench for deserializer: directed scenarios plus randomized
// frames, compared against a frame-level reference model that collects the
// bits of each frame and judges the frame as a whole.
module tb_deserializer;

  localparam int N   = 8;
  localparam int L   = 4;
  localparam int T   = 4;
  localparam int CS  = L + N + T;
  localparam int CS1 = L + 1 + T;

  logic         Clk = 1'b0;
  logic         Clr;
  logic         Trigger, InputBit;
  logic [N-1:0] DataOut;
  logic         DataValid, FrameError, Busy;
  logic [7:0]   ErrorCount;

  logic         Trigger1, InputBit1;
  logic [0:0]   DataOut1;
  logic         DataValid1, FrameError1, Busy1;
  logic [7:0]   ErrorCount1;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic         m_bits[$];
  bit           m_active;
  logic         exp_valid, exp_ferr, exp_busy;
  logic [N-1:0] exp_data;
  int           exp_cnt;

  deserializer #(.NumbDataBits(N), .NumbLeadingZeros(L), .NumbTrailingZeros(T)) dut (
    .Clk(Clk), .Clr(Clr), .Trigger(Trigger), .InputBit(InputBit),
    .DataOut(DataOut), .DataValid(DataValid), .FrameError(FrameError),
    .Busy(Busy), .ErrorCount(ErrorCount)
  );

  deserializer #(.NumbDataBits(1), .NumbLeadingZeros(L), .NumbTrailingZeros(T)) dut1 (
    .Clk(Clk), .Clr(Clr), .Trigger(Trigger1), .InputBit(InputBit1),
    .DataOut(DataOut1), .DataValid(DataValid1), .FrameError(FrameError1),
    .Busy(Busy1), .ErrorCount(ErrorCount1)
  );

  always #5 Clk = ~Clk;

  function automatic void model_reset();
    m_bits.delete();
    m_active  = 1'b0;
    exp_valid = 1'b0;
    exp_ferr  = 1'b0;
    exp_busy  = 1'b0;
    exp_data  = '0;
    exp_cnt   = 0;
  endfunction

  // One sampled bit: collect it into the open frame; judge full frames.
  function automatic void model_edge(input logic trig, input logic b);
    int word;
    bit pad_ok;
    exp_valid = 1'b0;
    exp_ferr  = 1'b0;
    if (trig) begin
      if (m_active) begin
        exp_ferr = 1'b1;
        if (exp_cnt < 255) exp_cnt++;
      end
      m_active = 1'b1;
      m_bits.delete();
      m_bits.push_back(b);
    end else if (m_active) begin
      m_bits.push_back(b);
      if (m_bits.size() == CS) begin
        pad_ok = 1'b1;
        word   = 0;
        for (int i = 0; i < CS; i++) begin
          if (i < L || i >= L + N) begin
            if (m_bits[i]) pad_ok = 1'b0;
          end else begin
            word = word * 2 + int'(m_bits[i]);
          end
        end
        if (pad_ok) begin
          exp_valid = 1'b1;
          exp_data  = word[N-1:0];
        end else begin
          exp_ferr = 1'b1;
          if (exp_cnt < 255) exp_cnt++;
        end
        m_active = 1'b0;
      end
    end
    exp_busy = m_active;
  endfunction

  function automatic logic [N+10:0] observed();
    return {DataValid, FrameError, Busy, DataOut, ErrorCount};
  endfunction

  function automatic logic [N+10:0] expected();
    return {exp_valid, exp_ferr, exp_busy, exp_data, exp_cnt[7:0]};
  endfunction

  // Frame bits, position 0 in the MSB; err_mask flips selected positions.
  function automatic logic [CS-1:0] frame_bits(input logic [N-1:0] d, input logic [CS-1:0] err_mask);
    return {{L{1'b0}}, d, {T{1'b0}}} ^ err_mask;
  endfunction

  function automatic logic [CS-1:0] random_pad_error();
    logic [CS-1:0] m;
    int p;
    m = '0;
    p = $urandom_range(1, 7);
    if (p > 3) p = p + 8;
    m[CS-1-p] = 1'b1;
    return m;
  endfunction

  task automatic tick(input logic trig, input logic b);
    Trigger  = trig;
    InputBit = b;
    @(posedge Clk);
    model_edge(trig, b);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge Clk);
    #1;
    total++;
    if (observed() !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", observed());
    end
    total++;
    if ({DataValid1, FrameError1, Busy1, DataOut1, ErrorCount1} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs_n1 got=%h want=0", {DataValid1, FrameError1, Busy1, DataOut1, ErrorCount1});
    end
    Clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)));
      total++;
      if (observed() !== expected()) begin
        bad++;
        $display("FAIL idle_ignores_input cyc=%0d got=%h want=%h", i, observed(), expected());
      end
    end
  endtask

  task automatic test_single_frame();
    logic [CS-1:0] f;
    f = frame_bits(8'hA5, '0);
    for (int i = 0; i < CS; i++) begin
      tick(i == 0, f[CS-1-i]);
      total++;
      if (observed() !== expected()) begin
        bad++;
        $display("FAIL single_frame cyc=%0d got=%h want=%h", i, observed(), expected());
      end
      if (i == CS - 1) begin
        total++;
        if ({DataValid, DataOut, Busy} !== {1'b1, 8'hA5, 1'b0}) begin
          bad++;
          $display("FAIL single_frame_strobe got v=%b d=%h b=%b want v=1 d=a5 b=0", DataValid, DataOut, Busy);
        end
      end
    end
    tick(1'b0, 1'b0);
    total++;
    if (DataValid !== 1'b0) begin
      bad++;
      $display("FAIL single_frame_pulse_width got=%b want=0", DataValid);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0]  words[3];
    logic [CS-1:0] f;
    int cyc, last_valid, seen;
    words      = '{8'h3C, 8'hFF, 8'h01};
    cyc        = 0;
    last_valid = -1;
    seen       = 0;
    for (int k = 0; k < 3; k++) begin
      f = frame_bits(words[k], '0);
      for (int i = 0; i < CS; i++) begin
        tick(i == 0, f[CS-1-i]);
        cyc++;
        total++;
        if (observed() !== expected()) begin
          bad++;
          $display("FAIL back_to_back frame=%0d cyc=%0d got=%h want=%h", k, i, observed(), expected());
        end
        if (DataValid === 1'b1) begin
          seen++;
          if (last_valid >= 0) begin
            total++;
            if (cyc - last_valid != CS) begin
              bad++;
              $display("FAIL back_to_back_period got=%0d want=%0d", cyc - last_valid, CS);
            end
          end
          last_valid = cyc;
        end
      end
    end
    total++;
    if (seen != 3 || DataOut !== 8'h01 || ErrorCount !== 8'd0) begin
      bad++;
      $display("FAIL back_to_back_summary got strobes=%0d d=%h errs=%0d want 3 01 0", seen, DataOut, ErrorCount);
    end
  endtask

  task automatic test_padding_error();
    logic [CS-1:0] f;
    f = frame_bits(8'h5A, 16'h0002);
    for (int i = 0; i < CS; i++) begin
      tick(i == 0, f[CS-1-i]);
      total++;
      if (observed() !== expected()) begin
        bad++;
        $display("FAIL padding_error cyc=%0d got=%h want=%h", i, observed(), expected());
      end
    end
    total++;
    if ({FrameError, DataValid, DataOut, ErrorCount} !== {1'b1, 1'b0, 8'h01, 8'd1}) begin
      bad++;
      $display("FAIL padding_error_end got e=%b v=%b d=%h c=%0d want e=1 v=0 d=01 c=1",
               FrameError, DataValid, DataOut, ErrorCount);
    end
  endtask

  task automatic test_early_trigger();
    logic [CS-1:0] f;
    f = frame_bits(8'h77, '0);
    for (int i = 0; i < 7; i++) begin
      tick(i == 0, f[CS-1-i]);
      total++;
      if (observed() !== expected()) begin
        bad++;
        $display("FAIL early_first cyc=%0d got=%h want=%h", i, observed(), expected());
      end
    end
    f = frame_bits(8'h81, '0);
    for (int i = 0; i < CS; i++) begin
      tick(i == 0, f[CS-1-i]);
      total++;
      if (observed() !== expected()) begin
        bad++;
        $display("FAIL early_second cyc=%0d got=%h want=%h", i, observed(), expected());
      end
      if (i == 0) begin
        total++;
        if ({FrameError, Busy, ErrorCount} !== {1'b1, 1'b1, 8'd2}) begin
          bad++;
          $display("FAIL early_abort got e=%b b=%b c=%0d want e=1 b=1 c=2", FrameError, Busy, ErrorCount);
        end
      end
    end
    total++;
    if ({DataValid, DataOut} !== {1'b1, 8'h81}) begin
      bad++;
      $display("FAIL early_restart got v=%b d=%h want v=1 d=81", DataValid, DataOut);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [CS-1:0] f;
    f = frame_bits(8'h3E, '0);
    for (int i = 0; i < 6; i++) tick(i == 0, f[CS-1-i]);
    #2 Clr = 1'b0;
    #1;
    model_reset();
    total++;
    if (observed() !== '0) begin
      bad++;
      $display("FAIL reset_mid_frame_async got=%h want=0", observed());
    end
    @(posedge Clk);
    #1;
    total++;
    if (observed() !== '0) begin
      bad++;
      $display("FAIL reset_mid_frame_hold got=%h want=0", observed());
    end
    Clr = 1'b1;
    tick(1'b0, 1'b0);
    f = frame_bits(8'hC3, '0);
    for (int i = 0; i < CS; i++) begin
      tick(i == 0, f[CS-1-i]);
      total++;
      if (observed() !== expected()) begin
        bad++;
        $display("FAIL reset_mid_frame_next cyc=%0d got=%h want=%h", i, observed(), expected());
      end
    end
    total++;
    if ({DataValid, DataOut, ErrorCount} !== {1'b1, 8'hC3, 8'd0}) begin
      bad++;
      $display("FAIL reset_mid_frame_word got v=%b d=%h c=%0d want v=1 d=c3 c=0", DataValid, DataOut, ErrorCount);
    end
  endtask

  task automatic test_random();
    logic [CS-1:0] f, mask;
    int abort_at, gap;
    for (int k = 0; k < 60; k++) begin
      mask = '0;
      if ($urandom_range(0, 3) == 0) mask = random_pad_error();
      abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, CS - 1)) : CS;
      f = frame_bits(N'($urandom), mask);
      for (int i = 0; i < abort_at; i++) begin
        tick(i == 0, f[CS-1-i]);
        total++;
        if (observed() !== expected()) begin
          bad++;
          $display("FAIL random frame=%0d cyc=%0d got=%h want=%h", k, i, observed(), expected());
        end
      end
      if (abort_at == CS) begin
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          tick(1'b0, 1'($urandom_range(0, 1)));
          total++;
          if (observed() !== expected()) begin
            bad++;
            $display("FAIL random_gap frame=%0d got=%h want=%h", k, observed(), expected());
          end
        end
      end
    end
    for (int i = 0; i < CS + 2; i++) begin
      tick(1'b0, 1'b0);
      total++;
      if (observed() !== expected()) begin
        bad++;
        $display("FAIL random_drain cyc=%0d got=%h want=%h", i, observed(), expected());
      end
    end
  endtask

  task automatic test_saturation();
    logic [CS-1:0] f;
    Clr = 1'b0;
    @(posedge Clk);
    #1;
    model_reset();
    Clr = 1'b1;
    for (int k = 0; k < 260; k++) begin
      f = frame_bits(N'($urandom), random_pad_error());
      for (int i = 0; i < CS; i++) begin
        tick(i == 0, f[CS-1-i]);
        total++;
        if (observed() !== expected()) begin
          bad++;
          $display("FAIL saturation frame=%0d cyc=%0d got=%h want=%h", k, i, observed(), expected());
        end
      end
    end
    total++;
    if (ErrorCount !== 8'd255) begin
      bad++;
      $display("FAIL saturation_final got=%0d want=255", ErrorCount);
    end
  endtask

  task automatic test_n1();
    logic d;
    int cyc, last_valid;
    cyc        = 0;
    last_valid = -1;
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? 1'b1 : 1'b0;
      for (int i = 0; i < CS1; i++) begin
        Trigger1  = (i == 0);
        InputBit1 = (i == L) ? d : 1'b0;
        @(posedge Clk);
        #1;
        cyc++;
        total++;
        if ({DataValid1, FrameError1, Busy1} !== {(i == CS1 - 1), 1'b0, (i != CS1 - 1)}) begin
          bad++;
          $display("FAIL n1_strobe frame=%0d cyc=%0d got v=%b e=%b b=%b", k, i, DataValid1, FrameError1, Busy1);
        end
        if (DataValid1 === 1'b1) begin
          total++;
          if (DataOut1 !== d) begin
            bad++;
            $display("FAIL n1_word frame=%0d got=%b want=%b", k, DataOut1, d);
          end
          if (last_valid >= 0) begin
            total++;
            if (cyc - last_valid != CS1) begin
              bad++;
              $display("FAIL n1_period got=%0d want=%0d", cyc - last_valid, CS1);
            end
          end
          last_valid = cyc;
        end
      end
    end
    Trigger1 = 1'b0;
  endtask

  initial begin
    Clr       = 1'b0;
    Trigger   = 1'b0;
    InputBit  = 1'b0;
    Trigger1  = 1'b0;
    InputBit1 = 1'b0;
    model_reset();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_padding_error();
    test_early_trigger();
    test_reset_mid_frame();
    test_random();
    test_saturation();
    test_n1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
